rr_mux_arbiter: RTL and testbench
=================================

Name: rr_mux_arbiter

Overview:
Round-robin arbiter and sequencer that shares one W-bit multiplexed output path among N requesters. It selects one owner and drives the internal mux select from it. The selected requester's data is registered onto a single output. It sits in front of any consumer that must see one source at a time. Ownership is held while the owner keeps requesting, with a bounded hold time for fairness.

Parameters:
N, 2, number of requesters (>=2)
W, 1, data width per requester
MAX_HOLD, 8, max consecutive granted cycles while others wait; 0 = unlimited

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
req  input  N  request per requester, level-sensitive
data  input  N*W  packed requester data; requester i at bits [i*W +: W]
grant  output  N  one-hot current owner; all-zero when idle
grant_idx  output  IDXW  binary owner index; IDXW = clog2(N), minimum 1
out_valid  output  1  owner data valid this cycle
out_data  output  W  registered data of current owner

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- All outputs are registered. Values become visible one cycle after the inputs are sampled.
- Reset (async assert, any time, including mid-grant):
  - state=IDLE, grant=0, grant_idx=0, out_valid=0, out_data=0.
  - Rotation pointer ptr=0 and hold_cnt=0.
  - Deassertion is synchronised by the integrator. This block takes rst_n as given.
- Arbitration function: starting at ptr, pick the first index i (mod N) with req[i]=1 and i != excluded owner.
- IDLE:
  - If req=0, stay in IDLE.
  - Otherwise pick i. At the edge, set grant=1<<i, grant_idx=i, out_valid=1, out_data=data[i], ptr=(i+1) mod N, hold_cnt=0, and go to GRANT.
- GRANT, owner g, evaluated each edge:
  - Case a, req[g]=1 and no forced rotation: stay with g. out_data=data[g] and hold_cnt++ (saturating at MAX_HOLD).
  - Case b, forced rotation: MAX_HOLD!=0, hold_cnt==MAX_HOLD-1 and another req pending. Grant the next requester excluding g. There is no idle bubble.
  - Case c, req[g]=0 and another req pending: switch to it directly. No idle bubble.
  - Case d, req[g]=0 and no req: go to IDLE and clear grant, out_valid and out_data.
- No other request pending: the owner keeps the grant indefinitely regardless of MAX_HOLD.
- Simultaneous events: owner release plus a new request in the same cycle is case c. If the owner drops and re-raises req, it re-enters rotation as a normal requester.
- Grant is always one-hot or zero. out_valid==|grant. grant_idx is consistent with grant.
- data of non-owners is ignored. out_data tracks the owner's data with 1-cycle latency.

Optional Feature:
Macro: MUX_ARB_PRIO0_EN
- Defined: requester 0 is urgent. If req[0]=1 and owner!=0, requester 0 preempts at the next edge, overriding hold and rotation. While requester 0 owns, MAX_HOLD is ignored. ptr update is unchanged.
- Undefined: pure round-robin as above. No extra logic is present.

Decomposition:
- Shared include file mux_arb_defs.vh holds:
  - state encodings ARB_IDLE=1'b0 and ARB_GRANT=1'b1
  - the IDXW width helper
- One natural sub-module, rr_pick: combinational rotate-and-priority-encode.
  - Inputs: req, ptr, exclude mask.
  - Outputs: found, idx.
- The top module holds the FSM, hold counter, pointer and output registers.

Test Plan:
All directed tests use N=2, W=8, MAX_HOLD=4.
- Reset: rst_n=0 with req=2'b11 and no clock edges. Outputs go immediately to grant=00, grant_idx=0, out_valid=0, out_data=0x00.
- Single request: req=01, data0=0xA5. Next edge gives grant=01, out_valid=1, out_data=0xA5. Change data0 to 0x3C; out_data=0x3C one edge later.
- Fairness: req=11 from IDLE with ptr=0. grant=01 for exactly 4 cycles, then grant=10 for 4 cycles, then 01, with no cycle where grant=00.
- Release handoff: owner 1 with req=10; set req=01 in the same cycle. The next edge gives grant=01, out_data=data0, out_valid stays 1. Then req=00 gives grant=00 and out_data=0x00 after one edge.
- Reset mid-grant: owner 1 with hold_cnt=2; pulse rst_n low. Outputs clear asynchronously. After release, req=11 grants 01 first (ptr back to 0).
- MUX_ARB_PRIO0_EN defined: owner 1 holding; raise req[0]. The next edge gives grant=01 and it holds beyond 4 cycles while req=11. Without the macro, the same stimulus waits for rotation.

Source files
------------

// File: rtl/rr_mux_arbiter_pkg.sv
// Shared state encodings and width helpers for the round-robin mux arbiter.
// Optional build macro used by the arbiter top: MUX_ARB_PRIO0_EN.
package rr_mux_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // Index width, never narrower than one bit even for degenerate N.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_pick.sv
// Rotate-and-priority-encode: first eligible requester at or after ptr,
// skipping any requester flagged in the exclude mask.
module rr_pick
    import rr_mux_arbiter_pkg::*;
#(
    parameter int N = 2,
    localparam int IDXW = idx_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    input  logic [N-1:0]    exclude,
    output logic            found,
    output logic [IDXW-1:0] idx
);

    logic [N-1:0] cand;
    logic [N-1:0] rot;

    assign cand = req & ~exclude;

    // Rotating the doubled vector puts ptr at bit 0, so the lowest set bit wins.
    always_comb begin
        rot   = N'({cand, cand} >> ptr);
        found = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                idx   = IDXW'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one registered W-bit output among N requesters.
// Define MUX_ARB_PRIO0_EN to let requester 0 preempt any other owner.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int N        = 2,
    parameter int W        = 1,
    parameter int MAX_HOLD = 8,
    localparam int IDXW    = idx_width(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      req,
    input  logic [N*W-1:0]    data,
    output logic [N-1:0]      grant,
    output logic [IDXW-1:0]   grant_idx,
    output logic              out_valid,
    output logic [W-1:0]      out_data
);

    localparam int HCW = cnt_width(MAX_HOLD);
    localparam logic [HCW-1:0] HOLD_MAX  = HCW'(MAX_HOLD);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    arb_state_t      state;
    logic [IDXW-1:0] ptr;
    logic [HCW-1:0]  hold_cnt;

    logic [W-1:0]    lane [N];
    logic            pick_found;
    logic [IDXW-1:0] pick_idx;
    logic            owner_req;
    logic            force_rot;
    logic            preempt;
    logic            take;
    logic [IDXW-1:0] take_idx;
    logic [IDXW-1:0] take_next_ptr;
    logic [N-1:0]    take_onehot;

    for (genvar i = 0; i < N; i++) begin : g_lane
        assign lane[i] = data[i*W +: W];
    end

    // The current owner is always excluded; in IDLE grant is zero so nothing is.
    rr_pick #(.N(N)) u_pick (
        .req     (req),
        .ptr     (ptr),
        .exclude (grant),
        .found   (pick_found),
        .idx     (pick_idx)
    );

    assign owner_req = |(req & grant);

`ifdef MUX_ARB_PRIO0_EN
    assign force_rot = (MAX_HOLD != 0) && !grant[0] && (hold_cnt == HOLD_LAST) && pick_found;
    assign preempt   = force_rot || (req[0] && !grant[0]);
    assign take_idx  = (req[0] && !grant[0]) ? '0 : pick_idx;
`else
    assign force_rot = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST) && pick_found;
    assign preempt   = force_rot;
    assign take_idx  = pick_idx;
`endif

    // A new owner is taken when someone else waits and the owner let go or must yield.
    assign take          = pick_found && (!owner_req || preempt);
    assign take_next_ptr = (take_idx == IDXW'(N - 1)) ? '0 : take_idx + 1'b1;
    assign take_onehot   = N'(1) << take_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            grant     <= '0;
            grant_idx <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            ptr       <= '0;
            hold_cnt  <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (take) begin
                        state     <= ARB_GRANT;
                        grant     <= take_onehot;
                        grant_idx <= take_idx;
                        out_valid <= 1'b1;
                        out_data  <= lane[take_idx];
                        ptr       <= take_next_ptr;
                        hold_cnt  <= '0;
                    end
                end
                ARB_GRANT: begin
                    if (take) begin
                        grant     <= take_onehot;
                        grant_idx <= take_idx;
                        out_valid <= 1'b1;
                        out_data  <= lane[take_idx];
                        ptr       <= take_next_ptr;
                        hold_cnt  <= '0;
                    end else if (owner_req) begin
                        out_data <= lane[grant_idx];
                        if (hold_cnt != HOLD_MAX) begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end else begin
                        state     <= ARB_IDLE;
                        grant     <= '0;
                        grant_idx <= '0;
                        out_valid <= 1'b0;
                        out_data  <= '0;
                        hold_cnt  <= '0;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter with N=2, W=8, MAX_HOLD=4.
// Expectations follow MUX_ARB_PRIO0_EN when the macro is defined.
module tb_rr_mux_arbiter;

    localparam int N        = 2;
    localparam int W        = 8;
    localparam int MAX_HOLD = 4;
`ifdef MUX_ARB_PRIO0_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic [1:0]   req;
    logic [15:0]  data;
    logic [1:0]   grant;
    logic [0:0]   grant_idx;
    logic         out_valid;
    logic [7:0]   out_data;

    typedef struct {
        int         step;
        logic [1:0] grant;
        logic [0:0] idx;
        logic       valid;
        logic [7:0] dat;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   step     = 0;

    rr_mux_arbiter #(.N(N), .W(W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data      (data),
        .grant     (grant),
        .grant_idx (grant_idx),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input int stepno, input logic [1:0] eg,
                               input logic [0:0] ei, input logic ev, input logic [7:0] ed);
        checks++;
        if ({grant, grant_idx, out_valid, out_data} !== {eg, ei, ev, ed}) begin
            failures++;
            $display("[TB] FAIL %s step %0d: got grant=%b idx=%0d valid=%b data=%h, want grant=%b idx=%0d valid=%b data=%h",
                     tag, stepno, grant, grant_idx, out_valid, out_data, eg, ei, ev, ed);
        end
    endtask

    // Drive one cycle of inputs and queue what the outputs must show after the next edge.
    task automatic applyStimulus(input logic [1:0] r, input logic [7:0] d0, input logic [7:0] d1,
                                 input logic [1:0] eg, input logic [7:0] ed);
        exp_t e;
        @(negedge clk);
        req  = r;
        data = {d1, d0};
        step++;
        e.step  = step;
        e.grant = eg;
        e.idx   = eg[1];
        e.valid = |eg;
        e.dat   = ed;
        sb.push_back(e);
    endtask

    task automatic resetDut();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", step, 2'b00, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        req   = 2'b00;
        rst_n = 1'b1;
    endtask

    // Monitor: compares the oldest queued expectation just after each active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("cycle", e.step, e.grant, e.idx, e.valid, e.dat);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] d0;
        logic [7:0] d1;
        logic       owner;

        rst_n = 1'b1;
        req   = 2'b11;
        data  = 16'hFFFF;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("power_on_reset", 0, 2'b00, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        req   = 2'b00;
        rst_n = 1'b1;

        $display("[TB] idle and single request");
        applyStimulus(2'b00, 8'h00, 8'h00, 2'b00, 8'h00);
        applyStimulus(2'b01, 8'hA5, 8'hEE, 2'b01, 8'hA5);
        applyStimulus(2'b01, 8'h3C, 8'hEE, 2'b01, 8'h3C);
        applyStimulus(2'b00, 8'h3C, 8'hEE, 2'b00, 8'h00);

        $display("[TB] fairness from ptr=0");
        resetDut();
        for (int k = 0; k < 12; k++) begin
            d0    = 8'(8'h10 + k);
            d1    = 8'(8'h80 + k);
            owner = PRIO ? 1'b0 : 1'(((k / 4) % 2));
            applyStimulus(2'b11, d0, d1, owner ? 2'b10 : 2'b01, owner ? d1 : d0);
        end

        $display("[TB] release handoff");
        applyStimulus(2'b11, 8'h11, 8'h22, PRIO ? 2'b01 : 2'b10, PRIO ? 8'h11 : 8'h22);
        applyStimulus(2'b10, 8'h11, 8'h22, 2'b10, 8'h22);
        applyStimulus(2'b01, 8'h5A, 8'h22, 2'b01, 8'h5A);
        applyStimulus(2'b00, 8'h5A, 8'h22, 2'b00, 8'h00);

        $display("[TB] reset while owner 1 holds");
        applyStimulus(2'b10, 8'h01, 8'h91, 2'b10, 8'h91);
        applyStimulus(2'b10, 8'h01, 8'h92, 2'b10, 8'h92);
        applyStimulus(2'b10, 8'h01, 8'h93, 2'b10, 8'h93);
        resetDut();
        applyStimulus(2'b11, 8'h77, 8'h88, 2'b01, 8'h77);
        applyStimulus(2'b11, 8'h77, 8'h88, 2'b01, 8'h77);

        $display("[TB] requester 0 raised while owner 1 holds");
        applyStimulus(2'b10, 8'h77, 8'h88, 2'b10, 8'h88);
        applyStimulus(2'b10, 8'h77, 8'h88, 2'b10, 8'h88);
        for (int j = 0; j < 6; j++) begin
            owner = PRIO ? 1'b0 : (j < 2);
            applyStimulus(2'b11, 8'h77, 8'h88, owner ? 2'b10 : 2'b01, owner ? 8'h88 : 8'h77);
        end
        applyStimulus(2'b00, 8'h77, 8'h88, 2'b00, 8'h00);

        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: %0d expectations left, want 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
